tsf_timer_1m: RTL and testbench

TSF_TIMER_1M -- requirements
Module: tsf_timer_1m

---
 rtl/tsf_timer_1m.sv | 102 ++++++++++
 tb/tb_tsf_timer_1m.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tsf_timer_1m.sv
// tsf_timer_1m: 64-bit microsecond TSF counter with prescaler,
// edge-triggered load and an optional one-shot alarm.
// Ports: clk, rstn (async, active-low), clk_div_m1 (cycles/us - 1),
//   tsf_load_en/tsf_load_val (load on rising edge of en),
//   alarm_target/alarm_arm (alarm inputs), tsf_runtime_val (TSF),
//   tsf_pulse_1M (tick pulse), alarm_fire/alarm_armed (alarm status).
// Build option: define TSF_ALARM_EN to build the alarm state machine;
//   without it alarm_fire and alarm_armed are tied to 0.
module tsf_timer_1m #(
  parameter int unsigned CLK_DIV_M1_RST = 99
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  clk_div_m1,
  input  logic        tsf_load_en,
  input  logic [63:0] tsf_load_val,
  input  logic [63:0] alarm_target,
  input  logic        alarm_arm,
  output logic [63:0] tsf_runtime_val,
  output logic        tsf_pulse_1M,
  output logic        alarm_fire,
  output logic        alarm_armed
);

  logic [7:0]  presc;
  logic        load_q;
  logic        load;
  logic        tick;
  logic [63:0] tsf_next;

  // The divisor is compared live every cycle; the reset default
  // only documents the expected 100 MHz integration value.
  logic [7:0] unused_div_rst;
  assign unused_div_rst = 8'(CLK_DIV_M1_RST);

  assign load     = tsf_load_en & ~load_q;
  // A load in the same cycle swallows the tick.
  assign tick     = ~load & (presc >= clk_div_m1);
  assign tsf_next = tsf_runtime_val + 64'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc           <= '0;
      load_q          <= 1'b0;
      tsf_runtime_val <= '0;
      tsf_pulse_1M    <= 1'b0;
    end else begin
      load_q <= tsf_load_en;
      if (load) begin
        tsf_runtime_val <= tsf_load_val;
        presc           <= '0;
        tsf_pulse_1M    <= 1'b0;
      end else if (tick) begin
        tsf_runtime_val <= tsf_next;
        presc           <= '0;
        tsf_pulse_1M    <= 1'b1;
      end else begin
        presc        <= presc + 8'd1;
        tsf_pulse_1M <= 1'b0;
      end
    end
  end

`ifdef TSF_ALARM_EN
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t state;
  logic   fire_q;
  logic   hit;

  // Target is compared live against the value the tick produces.
  assign hit = tick & (state == ARMED)
             & (tsf_next >= alarm_target);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      fire_q <= 1'b0;
    end else begin
      fire_q <= hit;
      // A re-arm in the firing cycle keeps the alarm armed.
      if (alarm_arm) begin
        state <= ARMED;
      end else if (hit) begin
        state <= IDLE;
      end
    end
  end

  assign alarm_fire  = fire_q;
  assign alarm_armed = (state == ARMED);
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_target, alarm_arm};
  assign alarm_fire   = 1'b0;
  assign alarm_armed  = 1'b0;
`endif

endmodule

// File: tb/tb_tsf_timer_1m.sv
// tb_tsf_timer_1m: directed bench for tsf_timer_1m.
// Table-driven prescaler/load vectors plus hand-written sequences.
module tb_tsf_timer_1m;

`ifdef TSF_ALARM_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  clk_div_m1 = 8'd99;
  logic        tsf_load_en = 1'b0;
  logic [63:0] tsf_load_val = '0;
  logic [63:0] alarm_target = '0;
  logic        alarm_arm = 1'b0;
  logic [63:0] tsf_runtime_val;
  logic        tsf_pulse_1M;
  logic        alarm_fire;
  logic        alarm_armed;

  int checks = 0;
  int errors = 0;

  tsf_timer_1m #(.CLK_DIV_M1_RST(99)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .clk_div_m1      (clk_div_m1),
    .tsf_load_en     (tsf_load_en),
    .tsf_load_val    (tsf_load_val),
    .alarm_target    (alarm_target),
    .alarm_arm       (alarm_arm),
    .tsf_runtime_val (tsf_runtime_val),
    .tsf_pulse_1M    (tsf_pulse_1M),
    .alarm_fire      (alarm_fire),
    .alarm_armed     (alarm_armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [63:0] val;
    logic [7:0]  div;
    logic        pulse;
    logic [63:0] tsf;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one cycle; release 1 ns after an edge so the
  // next rising edge is edge 1.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic row(input int i, input logic en,
                     input logic [63:0] val, input logic [7:0] div,
                     input logic pulse, input logic [63:0] tsf);
    tbl[i] = '{en, val, div, pulse, tsf};
  endtask

  localparam logic [63:0] FE = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int cnt;
    row(0,  1, FE,  3, 0, FE);
    row(1,  1, 0,   3, 0, FE);
    row(2,  0, 0,   3, 0, FE);
    row(3,  0, 0,   3, 0, FE);
    row(4,  0, 0,   3, 1, FF);
    row(5,  0, 0,   3, 0, FF);
    row(6,  0, 0,   3, 0, FF);
    row(7,  0, 0,   3, 0, FF);
    row(8,  0, 0,   3, 1, 0);
    row(9,  0, 0,   3, 0, 0);
    row(10, 0, 0,   3, 0, 0);
    row(11, 0, 0,   3, 0, 0);
    row(12, 1, 500, 3, 0, 500);
    row(13, 1, 500, 3, 0, 500);
    row(14, 1, 500, 3, 0, 500);
    row(15, 1, 500, 3, 0, 500);
    row(16, 1, 500, 3, 1, 501);
    row(17, 0, 0,   0, 1, 502);
    row(18, 0, 0,   0, 1, 503);

    // Reset state
    #12;
    check("rst_tsf", tsf_runtime_val, 0);
    check("rst_pulse", 64'(tsf_pulse_1M), 0);
    check("rst_fire", 64'(alarm_fire), 0);
    check("rst_armed", 64'(alarm_armed), 0);

    // 1000 cycles at divisor 99
    clk_div_m1 = 8'd99;
    do_reset();
    cnt = 0;
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (tsf_pulse_1M) begin
        cnt++;
        check("run_edge", 64'(e % 100), 0);
      end
    end
    check("run_cnt", 64'(cnt), 10);
    check("run_tsf", tsf_runtime_val, 10);

    // Table: wrap, held load, load-vs-tick, divisor 0
    tsf_load_en = 1'b0;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      tsf_load_en  = tbl[i].en;
      tsf_load_val = tbl[i].val;
      clk_div_m1   = tbl[i].div;
      step();
      check($sformatf("tbl_pulse[%0d]", i),
            64'(tsf_pulse_1M), 64'(tbl[i].pulse));
      check($sformatf("tbl_tsf[%0d]", i),
            tsf_runtime_val, tbl[i].tsf);
    end

    // Divisor lowered from 99 to 4 at prescaler 50
    tsf_load_en = 1'b0;
    clk_div_m1  = 8'd99;
    do_reset();
    for (int e = 1; e <= 50; e++) step();
    clk_div_m1 = 8'd4;
    for (int e = 51; e <= 61; e++) begin
      step();
      check($sformatf("div_pulse[%0d]", e), 64'(tsf_pulse_1M),
            64'(e == 51 || e == 56 || e == 61));
    end
    check("div_tsf", tsf_runtime_val, 3);

    // Load held high across reset release loads once
    tsf_load_en  = 1'b1;
    tsf_load_val = 64'd77;
    clk_div_m1   = 8'd9;
    do_reset();
    step();
    check("hold_tsf1", tsf_runtime_val, 77);
    tsf_load_val = 64'd88;
    step();
    check("hold_tsf2", tsf_runtime_val, 77);
    tsf_load_en = 1'b0;

    // Alarm sequence: fire at 13, no fire on load, re-arm wins
    clk_div_m1   = 8'd3;
    alarm_target = 64'd13;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      logic [63:0] et;
      tsf_load_en  = (e <= 2) || (e >= 15);
      tsf_load_val = (e <= 2) ? 64'd10 : 64'd20;
      alarm_arm    = (e == 2) || (e == 14) ||
                     (e == 20) || (e == 23);
      step();
      if (e < 5) et = 10;
      else if (e < 9) et = 11;
      else if (e < 13) et = 12;
      else if (e < 15) et = 13;
      else if (e < 19) et = 20;
      else if (e < 23) et = 21;
      else et = 22;
      check($sformatf("al_tsf[%0d]", e), tsf_runtime_val, et);
      check($sformatf("al_fire[%0d]", e), 64'(alarm_fire),
            64'(AL && (e == 13 || e == 19 || e == 23)));
      check($sformatf("al_armed[%0d]", e), 64'(alarm_armed),
            64'(AL && ((e >= 2 && e < 13) ||
                       (e >= 14 && e < 19) || e >= 20)));
    end
    alarm_arm   = 1'b0;
    tsf_load_en = 1'b0;

    // Reset mid-period with alarm armed
    clk_div_m1   = 8'd4;
    alarm_target = 64'd1000;
    do_reset();
    alarm_arm = 1'b1;
    step();
    alarm_arm = 1'b0;
    for (int e = 2; e <= 30; e++) step();
    check("mr_tsf", tsf_runtime_val, 6);
    check("mr_pulse", 64'(tsf_pulse_1M), 1);
    check("mr_armed", 64'(alarm_armed), 64'(AL));
    #2;
    rstn = 1'b0;
    #1;
    check("mr_rst_tsf", tsf_runtime_val, 0);
    check("mr_rst_pulse", 64'(tsf_pulse_1M), 0);
    check("mr_rst_armed", 64'(alarm_armed), 0);
    check("mr_rst_fire", 64'(alarm_fire), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("mr_pulse[%0d]", e),
            64'(tsf_pulse_1M), 64'(e == 5));
    end
    check("mr_tsf_end", tsf_runtime_val, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
